// File: rtl/ro_measure_ctrl.sv
// -----------------------------------------------------------------------------
// ro_measure_ctrl
//
// Ring-oscillator measurement controller. The controller enables one ring
// oscillator and lets it run for SETTLE_CYC clk cycles so it can stabilise.
// It then counts the RO's synchronized rising edges over a gate window of
// 2^gate_log2 clk cycles and reports the result with a one-cycle done pulse.
//
// Parameters
//   N_RO        number of ring oscillators (width of ro_in / ro_en)
//   CNT_W       width of the edge counter / count result
//   SETTLE_CYC  clk cycles the selected RO runs before counting (must be >= 1)
//
// Ports
//   clk         single clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   start       measurement request, sampled in IDLE only
//   abort       cancels a measurement in SETTLE / MEASURE
//   ro_sel      RO index, latched when start is accepted
//   gate_log2   gate window exponent, latched when start is accepted
//   ro_in       raw asynchronous (pre-divided) RO outputs
//   ro_en       one-hot RO enable (registered, glitch-free)
//   busy        high while in SETTLE or MEASURE
//   done        one-cycle pulse when count/overflow are valid
//   err         one-cycle pulse when start is rejected (ro_sel >= N_RO)
//   count       edge count of the last completed measurement
//   overflow    edge counter exceeded 2^CNT_W-1 during the window
//
// Build option
//   RO_COUNT_SATURATE_EN  defined: count saturates at 2^CNT_W-1.
//                         undefined (default): count wraps modulo 2^CNT_W.
//                         overflow sets on the first edge past 2^CNT_W-1
//                         in both builds.
// -----------------------------------------------------------------------------
module ro_measure_ctrl #(
  parameter  int N_RO       = 8,
  parameter  int CNT_W      = 16,
  parameter  int SETTLE_CYC = 16,
  localparam int SEL_W      = (N_RO > 1) ? $clog2(N_RO) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SEL_W-1:0] ro_sel,
  input  logic [3:0]       gate_log2,
  input  logic [N_RO-1:0]  ro_in,
  output logic [N_RO-1:0]  ro_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // Settle counter only needs to reach SETTLE_CYC-1.
  localparam int              SET_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DONE
  } state_e;

  state_e             state_q,      state_d;
  logic [SEL_W-1:0]   sel_q,        sel_d;
  logic [3:0]         gate_q,       gate_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [15:0]        win_cnt_q,    win_cnt_d;
  logic [CNT_W-1:0]   count_q,      count_d;
  logic               ovf_q,        ovf_d;
  logic               err_q,        err_d;
  logic [N_RO-1:0]    sync1_q,      sync1_d;
  logic [N_RO-1:0]    sync2_q,      sync2_d;
  logic               prev_q,       prev_d;
  logic [N_RO-1:0]    ro_en_q,      ro_en_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;

  logic               sel_ok;
  logic               sel_bit;
  logic               rise;
  logic [15:0]        win_last;

  // One-hot decode of an RO index. Indices >= N_RO never reach this (they are
  // rejected at start), so no guard is needed.
  function automatic logic [N_RO-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_RO-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign sel_ok   = (32'(ro_sel) < N_RO);
  assign sel_bit  = sync2_q[sel_q];
  assign rise     = sel_bit & ~prev_q;
  // Last window index: 2^gate-1, so gate=0 gives a single MEASURE cycle.
  assign win_last = (16'd1 << gate_q) - 16'd1;

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    sel_d        = sel_q;
    gate_d       = gate_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    err_d        = 1'b0;
    prev_d       = prev_q;

    // Two-flop synchronizer for every RO input.
    sync1_d = ro_in;
    sync2_d = sync1_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort has priority: start together with abort is simply dropped.
        if (start && !abort) begin
          if (sel_ok) begin
            state_d      = ST_SETTLE;
            sel_d        = ro_sel;
            gate_d       = gate_log2;
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            count_d      = '0;
            ovf_d        = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SETTLE: begin
        // Track the selected bit during settling so that a level that is
        // already high at MEASURE entry is not mistaken for a rising edge.
        prev_d = sel_bit;
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d   = ST_MEASURE;
          win_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end

      ST_MEASURE: begin
        prev_d = sel_bit;
        if (abort) begin
          state_d = ST_IDLE;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          if (rise) begin
`ifdef RO_COUNT_SATURATE_EN
            if (count_q == '1) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
`else
            count_d = count_q + CNT_W'(1);
            if (count_q == '1) begin
              ovf_d = 1'b1;
            end
`endif
          end
          if (win_cnt_q == win_last) begin
            state_d = ST_DONE;
          end else begin
            win_cnt_d = win_cnt_q + 16'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so ro_en never glitches
    // while the state vector changes.
    busy_d  = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
    done_d  = (state_d == ST_DONE);
    ro_en_d = busy_d ? onehot(sel_d) : '0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      gate_q       <= '0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      // NOTE: the synchronizer flops are reset as well, so no stale RO level
      // survives a reset into the next measurement's edge detector.
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= 1'b0;
      ro_en_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      gate_q       <= gate_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      ro_en_q      <= ro_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
